// File: rtl/lcd_nibble_writer_if.sv
// Sequencer-side handshake for lcd_nibble_writer: one byte per request,
// done_write pulse when the LCD has executed it.
interface lcd_nibble_writer_if;
    logic       ena_write;
    logic [7:0] data;
    logic       cmd_data;
    logic       done_write;
    logic       busy;

    modport master (output ena_write, data, cmd_data, input done_write, busy);
    modport slave  (input ena_write, data, cmd_data, output done_write, busy);
endinterface

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit write stage: high nibble, low nibble, execution wait, done pulse.
// Optional macro LCD_LONG_EXEC_EN: clear/home commands wait LONG_EXEC_CYC.
module lcd_nibble_writer #(
    parameter int SETUP_CYC     = 1,
    parameter int E_HIGH_CYC    = 1,
    parameter int HOLD_CYC      = 1,
    parameter int EXEC_CYC      = 40,
    parameter int LONG_EXEC_CYC = 1600
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    lcd_nibble_writer_if.slave seq,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d
);

    if (SETUP_CYC < 1 || SETUP_CYC > 65536 || E_HIGH_CYC < 1 || E_HIGH_CYC > 65536 ||
        HOLD_CYC < 1 || HOLD_CYC > 65536 || EXEC_CYC < 1 || EXEC_CYC > 65536 ||
        LONG_EXEC_CYC < 1 || LONG_EXEC_CYC > 65536) begin : g_bad_param
        $error("lcd_nibble_writer: cycle parameters must lie in 1..65536");
    end

    typedef enum logic [3:0] {
        IDLE, SETUP_H, EHI_H, HOLD_H, SETUP_L, EHI_L, HOLD_L, EXEC, DONE
    } state_t;

    // Counter holds remaining cycles minus one; a state ends when it reads zero.
    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] EHI_LD   = 16'(E_HIGH_CYC - 1);
    localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] EXEC_LD  = 16'(EXEC_CYC - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  byte_q;
    logic [15:0] exec_ld;

    assign lcd_rw = 1'b0;

`ifdef LCD_LONG_EXEC_EN
    localparam logic [15:0] LONG_LD = 16'(LONG_EXEC_CYC - 1);
    // lcd_rs carries the latched cmd_data, so RS=0 marks a command byte.
    logic long_cmd;
    assign long_cmd = !lcd_rs && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
    assign exec_ld  = long_cmd ? LONG_LD : EXEC_LD;
`else
    assign exec_ld = EXEC_LD;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            byte_q         <= '0;
            lcd_rs         <= 1'b0;
            lcd_e          <= 1'b0;
            lcd_d          <= '0;
            seq.done_write <= 1'b0;
            seq.busy       <= 1'b0;
        end else begin
            seq.done_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (seq.ena_write) begin
                        byte_q   <= seq.data;
                        lcd_rs   <= seq.cmd_data;
                        lcd_d    <= seq.data[7:4];
                        seq.busy <= 1'b1;
                        cnt      <= SETUP_LD;
                        state    <= SETUP_H;
                    end
                end
                DONE: begin
                    seq.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        case (state)
                            SETUP_H: begin lcd_e <= 1'b1; cnt <= EHI_LD;   state <= EHI_H;   end
                            EHI_H:   begin lcd_e <= 1'b0; cnt <= HOLD_LD;  state <= HOLD_H;  end
                            HOLD_H: begin
                                // Bus changes only here, one setup period before E rises.
                                lcd_d <= byte_q[3:0];
                                cnt   <= SETUP_LD;
                                state <= SETUP_L;
                            end
                            SETUP_L: begin lcd_e <= 1'b1; cnt <= EHI_LD;   state <= EHI_L;   end
                            EHI_L:   begin lcd_e <= 1'b0; cnt <= HOLD_LD;  state <= HOLD_L;  end
                            HOLD_L:  begin cnt <= exec_ld; state <= EXEC; end
                            EXEC:    begin seq.done_write <= 1'b1; state <= DONE; end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Scoreboard bench for lcd_nibble_writer: stimulus queues expected E pulses and
// done timing; a negedge monitor pops and compares as the LCD bus moves.
module tb_lcd_nibble_writer;

    localparam int LAT = 46;
`ifdef LCD_LONG_EXEC_EN
    localparam int LONG_LAT = 1606;
`else
    localparam int LONG_LAT = 46;
`endif

    logic       clk_1MHz = 1'b0;
    logic       rst_n    = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;

    lcd_nibble_writer_if sif ();

    lcd_nibble_writer u_dut (
        .clk_1MHz (clk_1MHz),
        .rst_n    (rst_n),
        .seq      (sif),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_d    (lcd_d)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    typedef struct {
        bit          is_done;
        logic        rs;
        logic [3:0]  nib;
        int unsigned cyc;
    } ev_t;

    ev_t         sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk_1MHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every E rising edge and every done pulse must match the queue head.
    logic       prev_e = 1'b0, prev_rs = 1'b0, prev_done = 1'b0;
    logic [3:0] prev_d = 4'h0;
    int         e_len = 0;

    always @(negedge clk_1MHz) begin : monitor
        ev_t ev;
        if (lcd_e) begin
            check("bus_stable_while_e", {27'd0, prev_rs, prev_d}, {27'd0, lcd_rs, lcd_d});
            e_len = prev_e ? e_len + 1 : 1;
        end
        if (lcd_e && !prev_e) begin
            check("e_pulse_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                ev = sb.pop_front();
                check("e_pulse_kind", ev.is_done, 0);
                check("e_pulse_rs", lcd_rs, ev.rs);
                check("e_pulse_nibble", lcd_d, ev.nib);
                check("e_pulse_rw", lcd_rw, 0);
            end
        end
        if (!lcd_e && prev_e) check("e_high_width", e_len, 1);
        if (sif.done_write) begin
            check("done_expected", (sb.size() != 0), 1);
            check("busy_during_done", sif.busy, 1);
            if (sb.size() != 0) begin
                ev = sb.pop_front();
                check("done_kind", ev.is_done, 1);
                check("done_cycle", cyc, ev.cyc);
            end
        end
        if (prev_done) begin
            check("done_single_pulse", sif.done_write, 0);
            check("busy_after_done", sif.busy, 0);
        end
        prev_e    = lcd_e;
        prev_rs   = lcd_rs;
        prev_d    = lcd_d;
        prev_done = sif.done_write;
    end

    task automatic request(input logic [7:0] d, input logic cd, input int lat, input bit expect_done);
        ev_t ev;
        @(negedge clk_1MHz);
        sif.ena_write = 1'b1;
        sif.data      = d;
        sif.cmd_data  = cd;
        ev = '{is_done: 1'b0, rs: cd, nib: d[7:4], cyc: 0};
        sb.push_back(ev);
        ev = '{is_done: 1'b0, rs: cd, nib: d[3:0], cyc: 0};
        sb.push_back(ev);
        if (expect_done) begin
            ev = '{is_done: 1'b1, rs: cd, nib: 4'h0, cyc: cyc + 1 + lat};
            sb.push_back(ev);
        end
        @(negedge clk_1MHz);
        sif.ena_write = 1'b0;
        sif.data      = ~d;
        sif.cmd_data  = ~cd;
        check("busy_on_accept", sif.busy, 1);
    endtask

    // Returns at the negedge on which done_write is visible.
    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk_1MHz);
            n++;
        end while (!sif.done_write && n < budget);
        check("done_within_budget", sif.done_write, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        sif.ena_write = 1'b0;
        sif.data      = 8'h00;
        sif.cmd_data  = 1'b0;
        repeat (3) @(negedge clk_1MHz);
        check("rst_done_write", sif.done_write, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_d", lcd_d, 0);
        rst_n = 1'b1;

        // Data byte, then command byte.
        request(8'h41, 1'b1, LAT, 1'b1);
        wait_done(60);
        request(8'h28, 1'b0, LAT, 1'b1);
        wait_done(60);

        // Requests while busy (mid-transfer and in DONE) are ignored.
        request(8'h36, 1'b1, LAT, 1'b1);
        repeat (8) @(negedge clk_1MHz);
        sif.ena_write = 1'b1; sif.data = 8'h55; sif.cmd_data = 1'b0;
        @(negedge clk_1MHz);
        sif.ena_write = 1'b0;
        wait_done(60);
        sif.ena_write = 1'b1; sif.data = 8'h55; sif.cmd_data = 1'b0;
        @(negedge clk_1MHz);
        sif.ena_write = 1'b0;
        check("ignored_in_done_busy", sif.busy, 0);
        repeat (5) @(negedge clk_1MHz);

        // Back-to-back: re-request in the first IDLE cycle after DONE.
        request(8'h33, 1'b1, LAT, 1'b1);
        wait_done(60);
        request(8'h38, 1'b0, LAT, 1'b1);
        wait_done(60);

        // Reset during EHI_L drops the byte.
        request(8'h9A, 1'b1, LAT, 1'b0);
        repeat (4) @(negedge clk_1MHz);
        check("in_ehi_l_e", lcd_e, 1);
        check("in_ehi_l_d", lcd_d, 4'hA);
        rst_n = 1'b0;
        @(negedge clk_1MHz);
        rst_n = 1'b1;
        check("midrst_lcd_e", lcd_e, 0);
        check("midrst_busy", sif.busy, 0);
        check("midrst_lcd_d", lcd_d, 0);
        check("midrst_lcd_rs", lcd_rs, 0);
        check("midrst_done", sif.done_write, 0);
        repeat (3) @(negedge clk_1MHz);
        request(8'h0C, 1'b0, LAT, 1'b1);
        wait_done(60);

        // Clear command (long wait only with the optional feature), then data 0x01.
        request(8'h01, 1'b0, LONG_LAT, 1'b1);
        wait_done(1700);
        request(8'h01, 1'b1, LAT, 1'b1);
        wait_done(60);

        repeat (20) @(negedge clk_1MHz);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
